// File: rtl/ps2_key_decoder_if.sv
// Output event stream of ps2_key_decoder: FWFT head entry with a valid/ready handshake.
// master = decoder (producer), slave = display/consumer logic.
interface ps2_key_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_ascii;
    logic [7:0] out_scan;

    modport master (output out_valid, output out_ascii, output out_scan, input out_ready);
    modport slave  (input out_valid, input out_ascii, input out_scan, output out_ready);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, typematic suppression, ASCII mapping, FWFT event FIFO.
// Optional macro PS2_SHIFT_EN adds left/right shift tracking and lowercase letters.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 code_valid,
    input  logic [7:0]           code,
    ps2_key_decoder_if.master    bus,
    output logic                 held,
    output logic [CNT_WIDTH-1:0] key_count,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] scan;
    } entry_t;

    // Returns 0x00 for unmapped codes; letters come back uppercase unless lower is set.
    function automatic logic [7:0] map_code(input logic [7:0] c, input logic lower);
        logic [7:0] a;
        case (c)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        if (lower && a >= 8'h41)
            a = a | 8'h20;
        return a;
    endfunction

    state_t           state;
    logic [7:0]       last_key;
    entry_t           head_q;
    entry_t           mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
    logic [AW:0]      count;
    logic             lower;
    logic [7:0]       ascii;
    logic             new_press, pop, full, push_ok, drop, head_load;
    entry_t           push_entry, head_d;

`ifdef PS2_SHIFT_EN
    logic lshift, rshift;
    assign lower = !(lshift || rshift);
`else
    assign lower = 1'b0;
`endif

    assign bus.out_valid = (count != '0);
    assign bus.out_ascii = head_q.ascii;
    assign bus.out_scan  = head_q.scan;

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        ascii      = map_code(code, lower);
        new_press  = code_valid && (state == IDLE) && (code != 8'hF0) && (code != 8'hE0)
                     && (ascii != 8'h00) && !(held && (code == last_key));
        push_entry = '{ascii: ascii, scan: code};
        pop        = (count != '0) && bus.out_ready;
        full       = (count == FULL_CNT);
        push_ok    = new_press && (!full || pop);
        drop       = new_press && full && !pop;
        rd_next    = rd_ptr + AW'(1);
        head_load  = 1'b0;
        head_d     = push_entry;
        // The head register only reloads when the FIFO stays non-empty, so it holds when drained.
        if (pop && (count != (AW+1)'(1))) begin
            head_load = 1'b1;
            head_d    = mem[rd_next];
        end else if (push_ok && ((count == '0) || pop)) begin
            head_load = 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; pointers and the registered head define what is visible.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= IDLE;
            last_key  <= 8'h00;
            held      <= 1'b0;
            key_count <= '0;
            overflow  <= 1'b0;
            head_q    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
`ifdef PS2_SHIFT_EN
            lshift    <= 1'b0;
            rshift    <= 1'b0;
`endif
        end else begin
            if (code_valid) begin
                case (state)
                    IDLE: begin
                        if (code == 8'hF0)
                            state <= BREAK;
                        else if (code == 8'hE0)
                            state <= EXT;
`ifdef PS2_SHIFT_EN
                        if (code == 8'h12) lshift <= 1'b1;
                        if (code == 8'h59) rshift <= 1'b1;
`endif
                    end
                    BREAK: begin
                        state <= IDLE;
                        if (held && (code == last_key))
                            held <= 1'b0;
`ifdef PS2_SHIFT_EN
                        if (code == 8'h12) lshift <= 1'b0;
                        if (code == 8'h59) rshift <= 1'b0;
`endif
                    end
                    EXT:       state <= (code == 8'hF0) ? EXT_BREAK : IDLE;
                    EXT_BREAK: state <= IDLE;
                    default:   state <= IDLE;
                endcase
            end

            if (new_press) begin
                held      <= 1'b1;
                last_key  <= code;
                key_count <= key_count + CNT_WIDTH'(1);
            end
            if (drop)
                overflow <= 1'b1;

            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_next;
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (head_load)
                head_q <= head_d;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus queues expected {ascii, scan} entries,
// a monitor pops and compares whenever the DUT hands over an entry.
module tb_ps2_key_decoder;
    logic       clk = 1'b0;
    logic       clrn;
    logic       code_valid;
    logic [7:0] code;
    logic       held;
    logic [7:0] key_count;
    logic       overflow;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .code_valid (code_valid),
        .code       (code),
        .bus        (bus),
        .held       (held),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: an entry is consumed on the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (clrn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_entry: got 0x%0h expected none", {bus.out_ascii, bus.out_scan});
            end else begin
                check("fifo_head", {bus.out_ascii, bus.out_scan}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic press_release(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        @(posedge clk);
        #1;
        clrn = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_empty_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        clrn          = 1'b0;
        code_valid    = 1'b0;
        code          = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_held", held, 0);
        check("rst_count", key_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ascii", bus.out_ascii, 0);
        check("rst_scan", bus.out_scan, 0);
        clrn = 1'b1;

        // Basic make/break with the consumer always ready.
        bus.out_ready = 1'b1;
        exp_q.push_back({8'h41, 8'h1C});
        send(8'h1C);
        check("t1_latency_valid", bus.out_valid, 1);
        check("t1_held_set", held, 1);
        check("t1_count", key_count, 1);
        send(8'hF0);
        send(8'h1C);
        check("t1_held_clear", held, 0);
        check("t1_count_after_break", key_count, 1);
        drain("t1");

        // Typematic repeats are suppressed.
        do_reset();
        bus.out_ready = 1'b0;
        exp_q.push_back({8'h30, 8'h45});
        send(8'h45); send(8'h45); send(8'h45); send(8'hF0); send(8'h45);
        check("t2_count", key_count, 1);
        check("t2_valid", bus.out_valid, 1);
        exp_q.push_back({8'h31, 8'h16});
        send(8'h16);
        check("t2_count2", key_count, 2);
        drain("t2");

        // Overflow on a depth-4 FIFO.
        do_reset();
        bus.out_ready = 1'b0;
        exp_q.push_back({8'h41, 8'h1C}); press_release(8'h1C);
        exp_q.push_back({8'h42, 8'h32}); press_release(8'h32);
        exp_q.push_back({8'h43, 8'h21}); press_release(8'h21);
        exp_q.push_back({8'h44, 8'h23}); press_release(8'h23);
        check("t3_no_overflow_yet", overflow, 0);
        send(8'h24);
        check("t3_overflow", overflow, 1);
        check("t3_count", key_count, 5);
        drain("t3");
        check("t3_overflow_sticky", overflow, 1);
        check("t3_hold_ascii", bus.out_ascii, 8'h44);
        check("t3_hold_scan", bus.out_scan, 8'h23);

        // Full FIFO with a simultaneous pop accepts the push.
        do_reset();
        bus.out_ready = 1'b0;
        exp_q.push_back({8'h41, 8'h1C}); press_release(8'h1C);
        exp_q.push_back({8'h42, 8'h32}); press_release(8'h32);
        exp_q.push_back({8'h43, 8'h21}); press_release(8'h21);
        exp_q.push_back({8'h44, 8'h23}); press_release(8'h23);
        exp_q.push_back({8'h46, 8'h2B});
        bus.out_ready = 1'b1;
        send(8'h2B);
        bus.out_ready = 1'b0;
        check("t3b_no_overflow", overflow, 0);
        check("t3b_count", key_count, 5);
        drain("t3b");

        // Extended sequences are discarded.
        do_reset();
        bus.out_ready = 1'b1;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check("t4_count", key_count, 0);
        check("t4_valid", bus.out_valid, 0);
        check("t4_held", held, 0);
        exp_q.push_back({8'h41, 8'h1C});
        send(8'h1C);
        check("t4_count_after", key_count, 1);
        drain("t4");

        // Reset in the middle of a break prefix.
        do_reset();
        bus.out_ready = 1'b1;
        exp_q.push_back({8'h42, 8'h32});
        send(8'h32);
        repeat (2) @(posedge clk);
        #1;
        send(8'hF0);
        do_reset();
        check("t5_rst_held", held, 0);
        check("t5_rst_count", key_count, 0);
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_overflow", overflow, 0);
        exp_q.push_back({8'h41, 8'h1C});
        send(8'h1C);
        check("t5_count", key_count, 1);
        drain("t5");

        // Unmapped makes leave held/last_key alone.
        do_reset();
        bus.out_ready = 1'b1;
`ifdef PS2_SHIFT_EN
        exp_q.push_back({8'h61, 8'h1C});
`else
        exp_q.push_back({8'h41, 8'h1C});
`endif
        send(8'h1C);
        send(8'h76);
        send(8'h1C);
        check("t6_count", key_count, 1);
        check("t6_held", held, 1);
        send(8'hF0); send(8'h1C);
`ifndef PS2_SHIFT_EN
        send(8'h12);
        check("t6_shift_unmapped_count", key_count, 1);
        check("t6_shift_unmapped_held", held, 0);
`endif
        drain("t6");

`ifdef PS2_SHIFT_EN
        // Shift selects case for letters.
        do_reset();
        bus.out_ready = 1'b1;
        exp_q.push_back({8'h61, 8'h1C});
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h12);
        check("t7_shift_no_count", key_count, 1);
        exp_q.push_back({8'h41, 8'h1C});
        send(8'h1C);
        send(8'hF0); send(8'h12);
        send(8'hF0); send(8'h1C);
        exp_q.push_back({8'h61, 8'h1C});
        send(8'h1C);
        check("t7_count", key_count, 3);
        drain("t7");
`endif

        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
